mc_ctrl_fsm: RTL and testbench

- Main control unit of the multicycle MIPS CPU: a Moore-style FSM that sequences fetch/decode/execute/memory/writeback.
- Drives every datapath enable and mux select.
- Produces the 2-bit alu_op consumed by the ALU control decoder (00 add, 01 decode funct, 10 sub).
- Guarantees that only supported funct codes ever reach the decoder with alu_op=01; anything else traps.

---
 rtl/mc_pkg.sv | 54 +++++
 rtl/mc_ctrl_outdec.sv | 84 ++++++++
 rtl/mc_ctrl_fsm.sv | 111 +++++++++++
 tb/tb_mc_ctrl_fsm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC     = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11,
    JUMP     = 4'd12,
    ILLEGAL  = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b01;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;

  localparam logic [1:0] ASB_B      = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Only these funct codes may reach the ALU decoder with alu_op=01.
  function automatic logic funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_ADDU) || (f == FN_SUB) ||
           (f == FN_AND) || (f == FN_OR)   || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of the FSM state (plus mem_ready in FETCH) into
// every datapath enable and mux select.
module mc_ctrl_outdec
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ASB_B;
    pc_src        = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    case (state_e'(state))
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ASB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE:   alu_src_b = ASB_IMM_SH;
      MEM_ADDR, ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
      end
      MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
      end
      ADDI_WB:  reg_write = 1'b1;
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM: state register, next-state logic,
// retired-instruction counter and sticky illegal-instruction trap.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  state_e           state_reg, state_next;
  logic             is_sw_reg, is_sw_next;
  logic             illegal_reg;
  logic [CNT_W-1:0] retired_reg;
  logic             retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      is_sw_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      is_sw_reg   <= is_sw_next;
      illegal_reg <= illegal_reg | (state_next == ILLEGAL);
      if (retire)
        retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  // Any entry into FETCH other than the initial one or a FETCH wait
  // marks the end of an instruction.
  assign retire = (state_next == FETCH) && (state_reg != IDLE) && (state_reg != FETCH);

  always_comb begin
    state_next = state_reg;
    // lw/sw is remembered at DECODE so MEM_ADDR ignores later opcode changes.
    is_sw_next = is_sw_reg;
    case (state_reg)
      IDLE:     state_next = FETCH;
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        is_sw_next = (opcode == OP_SW);
        case (opcode)
          OP_RTYPE:     state_next = funct_ok(funct) ? EXEC : ILLEGAL;
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDI_EX;
          OP_J:         state_next = JUMP;
          default:      state_next = ILLEGAL;
        endcase
      end
      MEM_ADDR: state_next = is_sw_reg ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) state_next = MEM_WB;
      MEM_WB:   state_next = FETCH;
      MEM_WR:   if (mem_ready) state_next = FETCH;
      EXEC:     state_next = R_WB;
      R_WB:     state_next = FETCH;
      BRANCH:   state_next = FETCH;
      ADDI_EX:  state_next = ADDI_WB;
      ADDI_WB:  state_next = FETCH;
      JUMP:     state_next = FETCH;
      ILLEGAL:  state_next = ILLEGAL;
      default:  state_next = IDLE;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state         (state_reg),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .alu_op        (alu_op)
  );

  assign illegal   = illegal_reg;
  assign retired   = retired_reg;
  assign state_dbg = state_reg;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_mc_ctrl_fsm;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                         S_MEM_ADDR = 4'd3, S_MEM_RD = 4'd4, S_MEM_WB = 4'd5,
                         S_MEM_WR = 4'd6, S_EXEC = 4'd7, S_R_WB = 4'd8,
                         S_BRANCH = 4'd9, S_ADDI_EX = 4'd10, S_ADDI_WB = 4'd11,
                         S_JUMP = 4'd12, S_ILLEGAL = 4'd13;

  // Control word: {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], pc_src[1:0], alu_op[1:0]}
  localparam logic [15:0] C_ZERO = 16'h0000, C_FETCH = 16'h9410, C_FETCH_W = 16'h1010,
                          C_DECODE = 16'h0030, C_ADDR = 16'h0060, C_MEM_RD = 16'h3000,
                          C_MEM_WB = 16'h0280, C_MEM_WR = 16'h2800, C_EXEC = 16'h0041,
                          C_R_WB = 16'h0180, C_BRANCH = 16'h4046, C_ADDI_WB = 16'h0080,
                          C_JUMP = 16'h8008;

  localparam logic [5:0] JF = 6'b000011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic [3:0] retired, state_dbg;
  logic [15:0] act_ctrl;

  mc_ctrl_fsm #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
    .illegal(illegal), .retired(retired), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign act_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_op};

  typedef struct packed {
    int          id;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [3:0]  ret;
    logic        ill;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         step_id = 0;
  logic [3:0] exp_ret = 4'd0;
  logic       exp_ill = 1'b0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, id, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("step %0d state=%0d ctrl=%h retired=%0d illegal=%0b",
               e.id, state_dbg, act_ctrl, retired, illegal);
      chk("state",   e.id, 32'(state_dbg), 32'(e.st));
      chk("ctrl",    e.id, 32'(act_ctrl),  32'(e.ctrl));
      chk("retired", e.id, 32'(retired),   32'(e.ret));
      chk("illegal", e.id, 32'(illegal),   32'(e.ill));
      checks++;
      if (alu_op === 2'b11) begin
        failures++;
        $display("FAIL alu_op11 step=%0d actual=%b required=not 11", e.id, alu_op);
      end
    end
  end

  task automatic step(input logic r, input logic mr, input logic [5:0] op, input logic [5:0] fn,
                      input logic [3:0] st, input logic [15:0] ctrl);
    @(posedge clk);
    #1;
    rst = r;
    mem_ready = mr;
    opcode = op;
    funct = fn;
    if (r) begin
      exp_ret = 4'd0;
      exp_ill = 1'b0;
    end
    step_id++;
    exp_q.push_back('{step_id, st, ctrl, exp_ret, exp_ill});
  endtask

  // jop is a misleading opcode driven outside DECODE; it must be ignored.
  task automatic fetch(input int stalls, input logic [5:0] jop);
    for (int i = 0; i < stalls; i++) step(0, 0, jop, JF, S_FETCH, C_FETCH_W);
    step(0, 1, jop, JF, S_FETCH, C_FETCH);
  endtask

  task automatic do_rtype(input logic [5:0] fn);
    fetch(0, 6'b100011);
    step(0, 1, 6'b000000, fn, S_DECODE, C_DECODE);
    step(0, 1, 6'b100011, JF, S_EXEC, C_EXEC);
    step(0, 1, 6'b100011, JF, S_R_WB, C_R_WB);
    exp_ret++;
  endtask

  task automatic do_lw(input int fstall, input int mstall);
    fetch(fstall, 6'b101011);
    step(0, 1, 6'b100011, JF, S_DECODE, C_DECODE);
    step(0, 1, 6'b101011, JF, S_MEM_ADDR, C_ADDR);
    for (int i = 0; i < mstall; i++) step(0, 0, 6'b101011, JF, S_MEM_RD, C_MEM_RD);
    step(0, 1, 6'b101011, JF, S_MEM_RD, C_MEM_RD);
    step(0, 1, 6'b101011, JF, S_MEM_WB, C_MEM_WB);
    exp_ret++;
  endtask

  task automatic do_sw(input int fstall, input int mstall);
    fetch(fstall, 6'b100011);
    step(0, 1, 6'b101011, JF, S_DECODE, C_DECODE);
    step(0, 1, 6'b100011, JF, S_MEM_ADDR, C_ADDR);
    for (int i = 0; i < mstall; i++) step(0, 0, 6'b100011, JF, S_MEM_WR, C_MEM_WR);
    step(0, 1, 6'b100011, JF, S_MEM_WR, C_MEM_WR);
    exp_ret++;
  endtask

  task automatic do_two(input logic [5:0] op, input logic [3:0] st, input logic [15:0] ctrl);
    fetch(0, 6'b000000);
    step(0, 1, op, JF, S_DECODE, C_DECODE);
    step(0, 1, 6'b000000, JF, st, ctrl);
    exp_ret++;
  endtask

  task automatic do_addi();
    fetch(0, 6'b000000);
    step(0, 1, 6'b001000, JF, S_DECODE, C_DECODE);
    step(0, 1, 6'b000000, JF, S_ADDI_EX, C_ADDR);
    step(0, 1, 6'b000000, JF, S_ADDI_WB, C_ADDI_WB);
    exp_ret++;
  endtask

  task automatic do_illegal(input logic [5:0] op, input logic [5:0] fn);
    fetch(0, 6'b000000);
    step(0, 1, op, fn, S_DECODE, C_DECODE);
    exp_ill = 1'b1;
    // Valid-looking R-type held in ILLEGAL must not wake the FSM.
    for (int i = 0; i < 3; i++) step(0, 1, 6'b000000, 6'b100000, S_ILLEGAL, C_ZERO);
    step(0, 1, 6'b000000, fn, S_ILLEGAL, C_ZERO);
  endtask

  task automatic do_reset();
    step(1, 1, 6'b000000, JF, S_IDLE, C_ZERO);
    step(1, 1, 6'b000000, JF, S_IDLE, C_ZERO);
    step(0, 1, 6'b000000, JF, S_IDLE, C_ZERO);
  endtask

  initial begin
    do_reset();
    do_rtype(6'b100000);
    do_lw(0, 3);
    do_sw(1, 1);
    do_two(6'b000100, S_BRANCH, C_BRANCH);
    do_two(6'b000010, S_JUMP, C_JUMP);
    do_addi();
    do_rtype(6'b100010);
    do_rtype(6'b100101);
    do_rtype(6'b101010);
    // Reset asserted while MEM_RD is waiting on memory.
    fetch(0, 6'b000000);
    step(0, 1, 6'b100011, JF, S_DECODE, C_DECODE);
    step(0, 1, 6'b101011, JF, S_MEM_ADDR, C_ADDR);
    step(0, 0, 6'b101011, JF, S_MEM_RD, C_MEM_RD);
    do_reset();
    for (int i = 0; i < 17; i++) do_addi();
    do_illegal(6'b000000, 6'b000011);
    do_reset();
    do_illegal(6'b111111, 6'b100000);
    do_reset();
    fetch(0, 6'b000000);
    @(negedge clk);
    #1;
    chk("queue_drained", step_id, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
